wasca_sd_cmd_sequencer: RTL



---
 rtl/wasca_sd_cmd_sequencer.sv | 292 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/wasca_sd_cmd_sequencer.sv
// SD SPI-mode command sequencer: frames one command with CRC7, exchanges bytes
// through the SPI master register port (TRDY/RRDY handshakes) and collects R1 plus up to 4 extra bytes.
module wasca_sd_cmd_sequencer #(
  parameter int NCR_MAX = 8,
  parameter int PRE_FF  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic [2:0]  cmd_resp_len,
  input  logic        cmd_keep_cs,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [7:0]  r1,
  output logic [31:0] resp_data,
  output logic        spi_select,
  output logic [2:0]  spi_addr,
  output logic        spi_read_n,
  output logic        spi_write_n,
  output logic [15:0] spi_wdata,
  input  logic [15:0] spi_rdata,
  input  logic        spi_readyfordata,
  input  logic        spi_dataavailable
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_SEQ, ST_BUS_WR, ST_TX_WAIT, ST_TX_WR,
    ST_RX_WAIT, ST_RX_RD, ST_RX_GAP, ST_DONE
  } state_t;

  typedef enum logic [3:0] {
    SP_CFG_SS, SP_CFG_STAT, SP_CS_ON, SP_PRE, SP_CMD,
    SP_POLL, SP_RESP, SP_TRAIL, SP_CS_OFF, SP_FIN
  } step_t;

  state_t      r_state, w_state_nxt;
  step_t       r_step, w_step_nxt;
  logic [7:0]  r_cnt, w_cnt_nxt;
  logic        r_cyc, w_cyc_nxt;
  logic [5:0]  r_idx, w_idx_nxt;
  logic [31:0] r_arg, w_arg_nxt;
  logic [2:0]  r_len, w_len_nxt;
  logic        r_keep, w_keep_nxt;
  logic [6:0]  r_crc, w_crc_nxt;
  logic [7:0]  r_rx, w_rx_nxt;
  logic [7:0]  r_r1, w_r1_nxt;
  logic [31:0] r_resp, w_resp_nxt;
  logic        r_timeout, w_timeout_nxt;
  logic [2:0]  r_addr, w_addr_nxt;
  logic [15:0] r_wdata, w_wdata_nxt;
  logic [7:0]  w_cmd_byte;
  logic        w_unused;

  function automatic logic [6:0] f_crc7(input logic [6:0] crc, input logic [7:0] b);
    logic [6:0] c;
    logic       fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[6] ^ b[i];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  always_comb begin
    case (r_cnt[2:0])
      3'd0:    w_cmd_byte = {2'b01, r_idx};
      3'd1:    w_cmd_byte = r_arg[31:24];
      3'd2:    w_cmd_byte = r_arg[23:16];
      3'd3:    w_cmd_byte = r_arg[15:8];
      3'd4:    w_cmd_byte = r_arg[7:0];
      default: w_cmd_byte = {r_crc, 1'b1};
    endcase
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_step_nxt    = r_step;
    w_cnt_nxt     = r_cnt;
    w_cyc_nxt     = r_cyc;
    w_idx_nxt     = r_idx;
    w_arg_nxt     = r_arg;
    w_len_nxt     = r_len;
    w_keep_nxt    = r_keep;
    w_crc_nxt     = r_crc;
    w_rx_nxt      = r_rx;
    w_r1_nxt      = r_r1;
    w_resp_nxt    = r_resp;
    w_timeout_nxt = r_timeout;
    w_addr_nxt    = r_addr;
    w_wdata_nxt   = r_wdata;
    case (r_state)
      ST_IDLE: begin
        if (cmd_start) begin
          w_idx_nxt     = cmd_index;
          w_arg_nxt     = cmd_arg;
          w_len_nxt     = (cmd_resp_len > 3'd4) ? 3'd4 : cmd_resp_len;
          w_keep_nxt    = cmd_keep_cs;
          w_crc_nxt     = 7'd0;
          w_timeout_nxt = 1'b0;
          w_r1_nxt      = 8'hFF;
          w_resp_nxt    = 32'd0;
          w_step_nxt    = SP_CFG_SS;
          w_cnt_nxt     = 8'd0;
          w_state_nxt   = ST_SEQ;
        end
      end
      // Dispatch: one select-idle cycle that launches the next register access.
      ST_SEQ: begin
        w_cyc_nxt = 1'b0;
        case (r_step)
          SP_CFG_SS: begin
            w_addr_nxt  = 3'd5;
            w_wdata_nxt = 16'h0001;
            w_step_nxt  = SP_CFG_STAT;
            w_state_nxt = ST_BUS_WR;
          end
          SP_CFG_STAT: begin
            w_addr_nxt  = 3'd2;
            w_wdata_nxt = 16'h0000;
            w_step_nxt  = SP_CS_ON;
            w_state_nxt = ST_BUS_WR;
          end
          SP_CS_ON: begin
            w_addr_nxt  = 3'd3;
            w_wdata_nxt = 16'h0400;
            w_step_nxt  = SP_PRE;
            w_cnt_nxt   = 8'd0;
            w_state_nxt = ST_BUS_WR;
          end
          SP_PRE: begin
            if (r_cnt < 8'(PRE_FF)) begin
              w_addr_nxt  = 3'd1;
              w_wdata_nxt = 16'h00FF;
              w_cnt_nxt   = r_cnt + 8'd1;
              w_state_nxt = ST_TX_WAIT;
            end else begin
              w_step_nxt = SP_CMD;
              w_cnt_nxt  = 8'd0;
            end
          end
          SP_CMD: begin
            if (r_cnt < 8'd6) begin
              w_addr_nxt  = 3'd1;
              w_wdata_nxt = {8'h00, w_cmd_byte};
              if (r_cnt < 8'd5) w_crc_nxt = f_crc7(r_crc, w_cmd_byte);
              w_cnt_nxt   = r_cnt + 8'd1;
              w_state_nxt = ST_TX_WAIT;
            end else begin
              w_step_nxt = SP_POLL;
              w_cnt_nxt  = 8'd0;
            end
          end
          SP_POLL: begin
            if (r_cnt < 8'(NCR_MAX)) begin
              w_addr_nxt  = 3'd1;
              w_wdata_nxt = 16'h00FF;
              w_cnt_nxt   = r_cnt + 8'd1;
              w_state_nxt = ST_TX_WAIT;
            end else begin
              w_timeout_nxt = 1'b1;
              w_r1_nxt      = 8'hFF;
              w_step_nxt    = r_keep ? SP_FIN : SP_TRAIL;
            end
          end
          SP_RESP: begin
            if (r_cnt < {5'd0, r_len}) begin
              w_addr_nxt  = 3'd1;
              w_wdata_nxt = 16'h00FF;
              w_cnt_nxt   = r_cnt + 8'd1;
              w_state_nxt = ST_TX_WAIT;
            end else begin
              w_step_nxt = r_keep ? SP_FIN : SP_TRAIL;
            end
          end
          SP_TRAIL: begin
            w_addr_nxt  = 3'd1;
            w_wdata_nxt = 16'h00FF;
            w_step_nxt  = SP_CS_OFF;
            w_state_nxt = ST_TX_WAIT;
          end
          SP_CS_OFF: begin
            w_addr_nxt  = 3'd3;
            w_wdata_nxt = 16'h0000;
            w_step_nxt  = SP_FIN;
            w_state_nxt = ST_BUS_WR;
          end
          default: w_state_nxt = ST_DONE;
        endcase
      end
      ST_BUS_WR: begin
        if (r_cyc) w_state_nxt = ST_SEQ;
        else       w_cyc_nxt   = 1'b1;
      end
      ST_TX_WAIT: begin
        if (spi_readyfordata) begin
          w_cyc_nxt   = 1'b0;
          w_state_nxt = ST_TX_WR;
        end
      end
      ST_TX_WR: begin
        if (r_cyc) w_state_nxt = ST_RX_WAIT;
        else       w_cyc_nxt   = 1'b1;
      end
      ST_RX_WAIT: begin
        if (spi_dataavailable) begin
          w_addr_nxt  = 3'd0;
          w_cyc_nxt   = 1'b0;
          w_state_nxt = ST_RX_RD;
        end
      end
      ST_RX_RD: begin
        if (r_cyc) begin
          w_rx_nxt    = spi_rdata[7:0];
          w_state_nxt = ST_RX_GAP;
        end else begin
          w_cyc_nxt = 1'b1;
        end
      end
      // r_cnt was already advanced when the byte was issued, so it is 1-based here.
      ST_RX_GAP: begin
        w_state_nxt = ST_SEQ;
        if (r_step == SP_POLL && !r_rx[7]) begin
          w_r1_nxt   = r_rx;
          w_step_nxt = SP_RESP;
          w_cnt_nxt  = 8'd0;
        end else if (r_step == SP_RESP) begin
          case (r_cnt)
            8'd1:    w_resp_nxt[31:24] = r_rx;
            8'd2:    w_resp_nxt[23:16] = r_rx;
            8'd3:    w_resp_nxt[15:8]  = r_rx;
            default: w_resp_nxt[7:0]   = r_rx;
          endcase
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_step    <= SP_CFG_SS;
      r_cnt     <= 8'd0;
      r_cyc     <= 1'b0;
      r_idx     <= 6'd0;
      r_arg     <= 32'd0;
      r_len     <= 3'd0;
      r_keep    <= 1'b0;
      r_crc     <= 7'd0;
      r_rx      <= 8'd0;
      r_r1      <= 8'hFF;
      r_resp    <= 32'd0;
      r_timeout <= 1'b0;
      r_addr    <= 3'd0;
      r_wdata   <= 16'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_step    <= w_step_nxt;
      r_cnt     <= w_cnt_nxt;
      r_cyc     <= w_cyc_nxt;
      r_idx     <= w_idx_nxt;
      r_arg     <= w_arg_nxt;
      r_len     <= w_len_nxt;
      r_keep    <= w_keep_nxt;
      r_crc     <= w_crc_nxt;
      r_rx      <= w_rx_nxt;
      r_r1      <= w_r1_nxt;
      r_resp    <= w_resp_nxt;
      r_timeout <= w_timeout_nxt;
      r_addr    <= w_addr_nxt;
      r_wdata   <= w_wdata_nxt;
    end
  end

  assign busy        = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign done        = (r_state == ST_DONE);
  assign timeout     = r_timeout;
  assign r1          = r_r1;
  assign resp_data   = r_resp;
  assign spi_select  = (r_state == ST_BUS_WR) || (r_state == ST_TX_WR) || (r_state == ST_RX_RD);
  assign spi_write_n = !((r_state == ST_BUS_WR) || (r_state == ST_TX_WR));
  assign spi_read_n  = !(r_state == ST_RX_RD);
  assign spi_addr    = r_addr;
  assign spi_wdata   = r_wdata;
  assign w_unused    = ^spi_rdata[15:8];

endmodule
